cube_result_collector: RTL and testbench

- Downstream consumer of the fixed-latency sum-of-cubes datapath (`out = a^3 + b^3`, 32-bit, mod 2^32, 5-cycle latency, no stall).
- Tracks which cycles issued valid operands and aligns that valid with the datapath output.
- Accumulates BATCH consecutive valid results into one wide sum.
- Buffers completed sums in a small FIFO behind a ready/valid master port. Because the datapath cannot stall, backpressure is absorbed by the FIFO, then results are dropped.

---
 rtl/cube_pkg.sv | 17 +
 rtl/cube_sum_fifo.sv | 61 ++++++
 rtl/cube_result_collector.sv | 130 +++++++++++++
 tb/tb_cube_result_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the sum-of-cubes datapath and its downstream collector.
package cube_pkg;

  localparam int CUBE_DATA_W  = 32;
  localparam int CUBE_LATENCY = 5;

  typedef logic [CUBE_DATA_W-1:0] cube_data_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cube_sum_fifo.sv
// Synchronous FIFO for completed batch sums.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop frees the head in the same cycle. head_o reads 0 while empty.
module cube_sum_fifo
  import cube_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Advance whichever pointer moved this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; emptying the FIFO on reset only needs these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/cube_result_collector.sv
// Downstream collector for the fixed-latency sum-of-cubes datapath.
// A delay line realigns issue_valid with cube_out, BATCH aligned results are
// summed into one ACC_W-wide beat, and beats queue in a small FIFO behind a
// ready/valid port. The datapath cannot stall, so a beat arriving at a full
// FIFO with no simultaneous pop is dropped and the sticky overflow flag set.
// Optional: define CUBE_COLLECT_DROP_CNT_EN to add a saturating 16-bit
// drop_count output; overflow is then derived from it.
// Parameter legality (LATENCY >= 1, BATCH >= 1, FIFO_DEPTH a power of two
// >= 2, ACC_W >= DATA_W + clog2(BATCH)) is the integrator's responsibility.
module cube_result_collector
  import cube_pkg::*;
#(
  parameter int DATA_W     = CUBE_DATA_W,
  parameter int LATENCY    = CUBE_LATENCY,
  parameter int BATCH      = 4,
  parameter int ACC_W      = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [DATA_W-1:0] cube_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_sum,
  output logic              overflow
`ifdef CUBE_COLLECT_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int               CNT_W    = (BATCH > 1) ? clog2(BATCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic               smp;
  logic [ACC_W-1:0]   acc_q, acc_d, total;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop, drop;
  logic               fifo_full, fifo_empty;

  // Valid delay line: the top bit is high exactly LATENCY cycles after an issue.
  always_comb begin
    vld_d = LATENCY'({vld_q, issue_valid});
  end

  assign smp = vld_q[LATENCY-1];

  // Batch accumulation; the final sample of a batch is pushed directly
  // instead of landing in acc_q, so the accumulator restarts at 0.
  always_comb begin
    total = acc_q + ACC_W'(cube_out);
    acc_d = acc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (smp) begin
      if (cnt_q == CNT_LAST) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Delay line, accumulator and batch count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  // A full FIFO only accepts a push when the head leaves in the same cycle.
  assign drop    = push && fifo_full && !pop;

  cube_sum_fifo #(
    .WIDTH (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (total),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (m_sum)
  );

`ifdef CUBE_COLLECT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped batches.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
  assign overflow   = (drop_cnt_q != 16'd0);
`else
  logic ovf_q;

  // Sticky overflow: set on the first dropped batch, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_cube_result_collector.sv
// Bench for cube_result_collector: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based model of batches and the output buffer.
module tb_cube_result_collector;

  localparam int DW    = 32;
  localparam int LAT   = 5;
  localparam int BATCH = 4;
  localparam int ACCW  = 40;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid = 1'b0;
  logic [DW-1:0]   cube_out = '0;
  logic            m_ready = 1'b0;
  logic            m_valid;
  logic [ACCW-1:0] m_sum;
  logic            overflow;
`ifdef CUBE_COLLECT_DROP_CNT_EN
  logic [15:0]     drop_count;
`endif

  always #5 clk = ~clk;

  cube_result_collector #(
    .DATA_W(DW), .LATENCY(LAT), .BATCH(BATCH), .ACC_W(ACCW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .cube_out    (cube_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sum       (m_sum),
    .overflow    (overflow)
`ifdef CUBE_COLLECT_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Issue times wait in a queue until LATENCY cycles have passed; each
  // aligned cube_out joins the current batch; a full batch becomes one sum
  // in the output queue, or is dropped if there is no room.
  int              mcyc = 0;
  int              issue_at[$];
  longint unsigned pend[$];
  longint unsigned mq[$];
  bit              m_ovf = 1'b0;
  int              m_drops = 0;
  bit              mpop;
  longint unsigned msum;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      issue_at.delete();
      pend.delete();
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      mpop = (mq.size() != 0) && m_ready;
      if (issue_valid) issue_at.push_back(mcyc);
      if (issue_at.size() != 0 && issue_at[0] + LAT == mcyc) begin
        void'(issue_at.pop_front());
        pend.push_back({32'd0, cube_out});
      end
      if (mpop) void'(mq.pop_front());
      if (pend.size() == BATCH) begin
        msum = 0;
        foreach (pend[i]) msum += pend[i];
        pend.delete();
        if (mq.size() < DEPTH) mq.push_back(msum);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      mcyc++;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("m_sum", 64'(m_sum), mq[0]);
      else                chk("m_sum", 64'(m_sum), 64'd0);
      chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef CUBE_COLLECT_DROP_CNT_EN
      chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    end
  end

  // ---------------- stimulus ----------------
  // The driver plays the datapath: each issue's result shows up on cube_out
  // LAT cycles later; other cycles carry a junk value.
  int          drv_c = 0;
  bit          iss_a[int];
  logic [31:0] val_a[int];

  task automatic step(input bit iv, input logic [31:0] v, input bit rdy);
    @(posedge clk);
    #1;
    iss_a[drv_c] = iv;
    val_a[drv_c] = v;
    issue_valid  = iv;
    m_ready      = rdy;
    if (iss_a.exists(drv_c - LAT) && iss_a[drv_c - LAT]) cube_out = val_a[drv_c - LAT];
    else                                                  cube_out = 32'hDEADBEEF;
    if (iss_a.exists(drv_c - 2*LAT)) begin
      iss_a.delete(drv_c - 2*LAT);
      val_a.delete(drv_c - 2*LAT);
    end
    drv_c++;
  endtask

  // Idle (ready=1) until m_valid rises; k counts cycles after the last issue.
  task automatic wait_valid(input string nm, input int exp_lat);
    int k;
    k = 0;
    do begin
      step(1'b0, 32'd0, 1'b1);
      k++;
    end while (!m_valid && k < 40);
    chk(nm, 64'(k), 64'(exp_lat));
  endtask

  // Asynchronous reset pulse, asserted and released between clock edges.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_sum", 64'(m_sum), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int vals[4];
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_sum", 64'(m_sum), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Basic batch: 9 + 35 + 1 + 27 = 72, valid 6 cycles after the last issue.
    vals = '{9, 35, 1, 27};
    foreach (vals[i]) step(1'b1, 32'(vals[i]), 1'b1);
    wait_valid("basic_latency", LAT + 1);
    chk("basic_sum", 64'(m_sum), 64'd72);
    step(1'b0, 32'd0, 1'b1);
    chk("basic_single_beat", 64'(m_valid), 64'd0);
    chk("basic_overflow", 64'(overflow), 64'd0);

    // Gapped issue at relative cycles 0, 3, 4, 10.
    step(1'b1, 32'd1, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'd2, 1'b1);
    step(1'b1, 32'd3, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'd4, 1'b1);
    wait_valid("gap_latency", LAT + 1);
    chk("gap_sum", 64'(m_sum), 64'd10);
    step(1'b0, 32'd0, 1'b1);

    // Full-width samples.
    repeat (4) step(1'b1, 32'hFFFFFFFF, 1'b1);
    wait_valid("width_latency", LAT + 1);
    chk("width_sum", 64'(m_sum), 64'h03_FFFF_FFFC);
    step(1'b0, 32'd0, 1'b1);

    // Backpressure: five batches summing to 1..5 with m_ready low.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 32'(k), 1'b0);
      repeat (3) step(1'b1, 32'd0, 1'b0);
    end
    repeat (LAT + 3) step(1'b0, 32'd0, 1'b0);
    chk("bp_overflow", 64'(overflow), 64'd1);
`ifdef CUBE_COLLECT_DROP_CNT_EN
    chk("bp_drop_count", 64'(drop_count), 64'd1);
`endif
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("bp_drain_sum", 64'(m_sum), 64'(k));
    end
    step(1'b0, 32'd0, 1'b1);
    chk("bp_drained", 64'(m_valid), 64'd0);

    // Full FIFO with a pop in the same cycle the fifth batch lands.
    reset_pulse();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 32'(10 * k), 1'b0);
      repeat (3) step(1'b1, 32'd0, 1'b0);
    end
    repeat (LAT - 1) step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("pp_head_before", 64'(m_sum), 64'd10);
    step(1'b0, 32'd0, 1'b0);
    chk("pp_overflow", 64'(overflow), 64'd0);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("pp_order", 64'(m_sum), 64'(10 * k));
    end
    step(1'b0, 32'd0, 1'b1);
    chk("pp_drained", 64'(m_valid), 64'd0);

    // Reset with a buffered beat and a half-done batch.
    repeat (4) step(1'b1, 32'd7, 1'b0);
    step(1'b1, 32'd5, 1'b0);
    step(1'b1, 32'd6, 1'b0);
    repeat (LAT + 1) step(1'b0, 32'd0, 1'b0);
    chk("mid_buffered", 64'(m_sum), 64'd28);
    reset_pulse();
    repeat (4) step(1'b1, 32'd1, 1'b1);
    wait_valid("mid_latency", LAT + 1);
    chk("mid_sum_after_reset", 64'(m_sum), 64'd4);
    step(1'b0, 32'd0, 1'b1);

    // Randomized traffic: bursty issue, varying readiness, rare resets.
    for (int n = 0; n < 3000; n++) begin
      int rdy_pct;
      rdy_pct = ((n / 400) % 2 == 0) ? 25 : 85;
      if ($urandom_range(0, 599) == 0) reset_pulse();
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < rdy_pct);
    end
    repeat (LAT + 12) step(1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
